// File: rtl/q2_pkg.sv
// Shared op encodings, FSM states and helpers for the q2 bit-serial executor.
package q2_pkg;

  typedef enum logic [2:0] {
    OpLoad = 3'b000,
    OpAdd  = 3'b001,
    OpAdc  = 3'b010,
    OpNor  = 3'b011,
    OpShr  = 3'b100,
    OpShl  = 3'b101,
    OpNop  = 3'b110
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  // Ops whose final carry register value becomes the new link flag.
  function automatic logic op_updates_flag(op_e op);
    return (op == OpAdd) || (op == OpAdc) || (op == OpShr) || (op == OpShl);
  endfunction

endpackage

// File: rtl/q2_serial_bit.sv
// Per-bit combine logic for the serial datapath plus the one-bit carry register.
module q2_serial_bit
  import q2_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic en_i,
  input  op_e  op_i,
  input  logic a_i,
  input  logic a_next_i,
  input  logic d_i,
  input  logic f_i,
  input  logic last_i,
  output logic res_o,
  output logic carry_next_o
);

  logic carry_q, carry_d, carry_init;

  always_comb begin
    res_o      = a_i;
    carry_d    = carry_q;
    carry_init = 1'b0;
    case (op_i)
      OpLoad: res_o = d_i;
      OpAdd, OpAdc: begin
        res_o      = a_i ^ d_i ^ carry_q;
        carry_d    = (a_i & d_i) | (carry_q & (a_i ^ d_i));
        carry_init = (op_i == OpAdc) ? f_i : 1'b0;
      end
      OpNor: res_o = ~(a_i | d_i);
      // Carry parks old A[0]; each result bit looks one position ahead, F fills the MSB.
      OpShr: begin
        res_o      = last_i ? f_i : a_next_i;
        carry_init = a_i;
      end
      // Carry delays A by one bit, seeded with F; ends holding old A[MSB].
      OpShl: begin
        res_o      = carry_q;
        carry_d    = a_i;
        carry_init = f_i;
      end
      default: res_o = a_i;
    endcase
    carry_next_o = carry_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      carry_q <= 1'b0;
    end else if (start_i) begin
      carry_q <= carry_init;
    end else if (en_i) begin
      carry_q <= carry_d;
    end
  end

endmodule

// File: rtl/q2_serial_exec.sv
// Bit-serial accumulator executor: one result bit per SHIFT cycle, LSB first,
// with the result streamed into the accumulator MSB as it shifts right.
module q2_serial_exec
  import q2_pkg::*;
#(
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] acc,
  output logic             flag,
  output logic             zero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  op_e              op_q, op_d, cur_op;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             flag_q, flag_d;
  logic             accept, shift_en, last, res, carry_next;

  assign accept   = (state_q == StIdle) && start;
  assign shift_en = (state_q == StShift);
  assign last     = shift_en && (cnt_q == LastCnt);
  // The bit slice needs the incoming op to seed its carry in the accept cycle.
  assign cur_op   = accept ? op_e'(op) : op_q;

  q2_serial_bit u_bit (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (accept),
    .en_i         (shift_en),
    .op_i         (cur_op),
    .a_i          (acc_q[0]),
    .a_next_i     (acc_q[1]),
    .d_i          (opnd_q[0]),
    .f_i          (flag_q),
    .last_i       (last),
    .res_o        (res),
    .carry_next_o (carry_next)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StShift;
          op_d    = op_e'(op);
          opnd_d  = operand;
          cnt_d   = '0;
        end
      end
      StShift: begin
        acc_d  = {res, acc_q[WIDTH-1:1]};
        opnd_d = opnd_q >> 1;
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          if (op_updates_flag(op_q)) begin
            flag_d = carry_next;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= OpNop;
      acc_q   <= '0;
      opnd_q  <= '0;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
    end
  end

  assign busy = (state_q == StShift);
  assign done = (state_q == StDone);
  assign acc  = acc_q;
  assign flag = flag_q;
  assign zero = (acc_q == '0);

endmodule

// File: tb/tb_q2_serial_exec.sv
// Scoreboard bench for q2_serial_exec: expectations queued at start, checked on done.
module tb_q2_serial_exec;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] operand = '0;
  logic         busy, done, flag, zero;
  logic [W-1:0] acc;

  typedef struct {
    logic [W-1:0] acc;
    logic         flag;
    int           c0;
  } exp_t;

  exp_t         sb[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           done_cnt = 0;
  logic [W-1:0] m_acc = '0;
  logic         m_flag = 1'b0;

  q2_serial_exec #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .operand (operand),
    .busy    (busy),
    .done    (done),
    .acc     (acc),
    .flag    (flag),
    .zero    (zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns {new_flag, new_acc}.
  function automatic logic [W:0] model(input logic [2:0] o, input logic [W-1:0] d,
                                       input logic [W-1:0] a, input logic f);
    case (o)
      3'd0:    return {f, d};
      3'd1:    return {1'b0, a} + {1'b0, d};
      3'd2:    return {1'b0, a} + {1'b0, d} + {{W{1'b0}}, f};
      3'd3:    return {f, ~(a | d)};
      3'd4:    return {a[0], f, a[W-1:1]};
      3'd5:    return {a, f};
      default: return {f, a};
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt <= done_cnt + 1;
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("acc", acc, e.acc);
        check("flag", flag, e.flag);
        check("zero", zero, e.acc == '0);
        check("latency", cyc - e.c0, W + 1);
        check("busy_in_done", busy, 0);
      end
    end
  end

  task automatic drive_start(input logic [2:0] o, input logic [W-1:0] d);
    @(posedge clk); #1;
    start   = 1'b1;
    op      = o;
    operand = d;
    {m_flag, m_acc} = model(o, d, m_acc, m_flag);
    sb.push_back('{acc: m_acc, flag: m_flag, c0: cyc});
    @(posedge clk); #1;
    start   = 1'b0;
    op      = 3'($urandom);
    operand = W'($urandom);
    @(negedge clk);
    check("busy_shift", busy, 1);
    check("done_shift", done, 0);
  endtask

  task automatic wait_done(input int base);
    for (int i = 0; i < 3 * W; i++) begin
      @(posedge clk); #2;
      if (done_cnt != base) return;
    end
    check("done_timeout", 0, 1);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] d);
    int base;
    base = done_cnt;
    drive_start(o, d);
    wait_done(base);
  endtask

  initial begin
    int base;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_acc", acc, 0);
    check("rst_flag", flag, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_zero", zero, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Wrap-around add, then ADC/ADD with carry in, NOR, LOAD.
    run_op(3'd0, 12'hFFF);
    run_op(3'd1, 12'h001);
    run_op(3'd0, 12'h123);
    run_op(3'd2, 12'h456);
    run_op(3'd0, 12'h123);
    run_op(3'd1, 12'h456);
    run_op(3'd0, 12'h0F0);
    run_op(3'd3, 12'h00F);
    run_op(3'd0, 12'hABC);
    // Rotates through F.
    run_op(3'd0, 12'h001);
    run_op(3'd4, 12'h000);
    run_op(3'd4, 12'h000);
    run_op(3'd5, 12'h000);
    run_op(3'd5, 12'h000);
    run_op(3'd6, 12'h555);
    run_op(3'd7, 12'hAAA);

    for (int i = 0; i < 24; i++) begin
      run_op(3'($urandom_range(0, 7)), W'($urandom));
    end

    // Starts during SHIFT (cycle 3) and DONE (cycle 13) must be ignored.
    base = done_cnt;
    drive_start(3'd1, 12'h321);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1; op = 3'd0; operand = 12'hDEF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    start = 1'b1; op = 3'd0; operand = 12'h777;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (W + 4) @(posedge clk);
    #2;
    check("ignored_start_dones", done_cnt - base, 1);
    check("ignored_start_busy", busy, 0);

    // Reset in SHIFT cycle 5 aborts with no done pulse.
    base = done_cnt;
    drive_start(3'd2, 12'h0FF);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1; start = 1'b1;
    void'(sb.pop_back());
    m_acc  = '0;
    m_flag = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("abort_acc", acc, 0);
    check("abort_flag", flag, 0);
    check("abort_busy", busy, 0);
    repeat (W + 3) @(posedge clk);
    #2;
    check("abort_no_done", done_cnt - base, 0);
    run_op(3'd0, 12'h5A5);
    run_op(3'd1, 12'hA5B);

    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule
